// File: rtl/adc_spi_multi_rx_pkg.sv
// Shared definitions for the multi-channel serial ADC receiver:
// FSM state encodings and default frame geometry.
package adc_spi_multi_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2,
    ST_QUIET = 2'd3
  } state_e;

  localparam int unsigned DEF_CHANNELS   = 2;
  localparam int unsigned DEF_FRAME_BITS = 16;
  localparam int unsigned DEF_DATA_BITS  = 12;
  localparam int unsigned DEF_CLK_DIV    = 2;
  localparam int unsigned DEF_QUIET_CYC  = 4;

  function automatic int unsigned max2(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/adc_spi_multi_rx_sclk_gen.sv
// sclk divider: toggles sclk every CLK_DIV clk cycles while enabled,
// parks sclk high otherwise; rise/fall flag the cycle ending in an edge.
module adc_sclk_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_q, div_d;
  logic          sclk_q, sclk_d;
  logic          tick;

  always_comb begin
    tick   = en && (div_q == DW'(CLK_DIV - 1));
    div_d  = div_q;
    sclk_d = sclk_q;
    if (!en) begin
      div_d  = '0;
      sclk_d = 1'b1;
    end else if (tick) begin
      div_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      div_d  = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q  <= '0;
      sclk_q <= 1'b1;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;
  assign rise = tick & ~sclk_q;
  assign fall = tick & sclk_q;

endmodule

// File: rtl/adc_spi_multi_rx.sv
// Multi-channel serial ADC front end sharing cs/sclk across CHANNELS ADCs.
// Define ADC_RX_AVG_EN to average every 4 frames before raising valid.
module adc_spi_multi_rx
  import adc_spi_multi_rx_pkg::*;
#(
  parameter int unsigned CHANNELS   = DEF_CHANNELS,
  parameter int unsigned FRAME_BITS = DEF_FRAME_BITS,
  parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
  parameter int unsigned QUIET_CYC  = DEF_QUIET_CYC
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          mode_cont,
  input  logic [CHANNELS-1:0]           sdata,
  output logic                          cs,
  output logic                          sclk,
  output logic [CHANNELS*DATA_BITS-1:0] data,
  output logic                          valid,
  output logic                          frame_err,
  output logic                          busy
);

  localparam int unsigned BW = $clog2(FRAME_BITS + 1);
  localparam int unsigned CW = $clog2(max2(CLK_DIV, QUIET_CYC) + 1);

  state_e                        state_q, state_d;
  logic                          cs_q, cs_d;
  logic                          busy_q, busy_d;
  logic                          valid_q, valid_d;
  logic                          ferr_q, ferr_d;
  logic [CHANNELS*DATA_BITS-1:0] data_q, data_d;
  logic [FRAME_BITS-1:0]         sr_q [CHANNELS];
  logic [FRAME_BITS-1:0]         sr_d [CHANNELS];
  logic [BW-1:0]                 bit_q, bit_d;
  logic [CW-1:0]                 cnt_q, cnt_d;

  logic [DATA_BITS-1:0] samp [CHANNELS];
  logic                 frame_bad;
  logic                 done;
  logic                 rise;
  logic                 fall;

`ifdef ADC_RX_AVG_EN
  localparam int unsigned AW = DATA_BITS + 2;

  logic [AW-1:0] acc_q [CHANNELS];
  logic [AW-1:0] acc_d [CHANNELS];
  logic [1:0]    fcnt_q, fcnt_d;
  logic          eacc_q, eacc_d;
  logic [AW-1:0] sum;
`endif

  adc_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == ST_SHIFT),
    .sclk (sclk),
    .rise (rise),
    .fall (fall)
  );

  // Leading (non-data) bits of every channel must be zero.
  always_comb begin
    frame_bad = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      samp[k]   = sr_q[k][DATA_BITS-1:0];
      frame_bad = frame_bad | (|(sr_q[k] >> DATA_BITS));
    end
  end

  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    ferr_d  = ferr_q;
    data_d  = data_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    done    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start || mode_cont) begin
          state_d = ST_SHIFT;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          bit_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (rise) begin
          for (int k = 0; k < CHANNELS; k++) begin
            sr_d[k] = {sr_q[k][FRAME_BITS-2:0], sdata[k]};
          end
          bit_d = bit_q + 1'b1;
          if (bit_q == BW'(FRAME_BITS - 1)) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q == CW'(CLK_DIV - 1)) begin
          state_d = ST_QUIET;
          cs_d    = 1'b1;
          cnt_d   = '0;
          done    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_QUIET: begin
        if (cnt_q == CW'(QUIET_CYC - 1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef ADC_RX_AVG_EN
    acc_d  = acc_q;
    fcnt_d = fcnt_q;
    eacc_d = eacc_q;
    sum    = '0;
    if (done) begin
      if (fcnt_q == 2'd3) begin
        valid_d = 1'b1;
        ferr_d  = eacc_q | frame_bad;
        fcnt_d  = '0;
        eacc_d  = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
          sum = acc_q[k] + AW'(samp[k]);
          data_d[k*DATA_BITS +: DATA_BITS] = DATA_BITS'(sum >> 2);
          acc_d[k] = '0;
        end
      end else begin
        fcnt_d = fcnt_q + 1'b1;
        eacc_d = eacc_q | frame_bad;
        for (int k = 0; k < CHANNELS; k++) begin
          acc_d[k] = acc_q[k] + AW'(samp[k]);
        end
      end
    end
`else
    if (done) begin
      valid_d = 1'b1;
      ferr_d  = frame_bad;
      for (int k = 0; k < CHANNELS; k++) begin
        data_d[k*DATA_BITS +: DATA_BITS] = samp[k];
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      data_q  <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        sr_q[k] <= '0;
      end
`ifdef ADC_RX_AVG_EN
      fcnt_q <= '0;
      eacc_q <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        acc_q[k] <= '0;
      end
`endif
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      data_q  <= data_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
`ifdef ADC_RX_AVG_EN
      fcnt_q <= fcnt_d;
      eacc_q <= eacc_d;
      acc_q  <= acc_d;
`endif
    end
  end

  // sclk may only move while a frame is being shifted.
  a_fall_in_shift: assert property (
    @(posedge clk) disable iff (!rst) fall |-> state_q == ST_SHIFT
  );

  assign cs        = cs_q;
  assign busy      = busy_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign data      = data_q;

endmodule

// File: tb/tb_adc_spi_multi_rx.sv
// Directed bench for adc_spi_multi_rx: default build plus a CLK_DIV=1 copy.
// With ADC_RX_AVG_EN defined, only reset and averaging scenarios run.
module tb_adc_spi_multi_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start1 = 1'b0;
  logic        mode_cont = 1'b0;
  logic [1:0]  sdata, sdata1;
  logic        cs, sclk, valid, frame_err, busy;
  logic        cs1, sclk1, valid1, frame_err1, busy1;
  logic [23:0] data, data1;

  logic [15:0] w0 = '0, w1 = '0, w10 = '0, w11 = '0;

  int tests = 0;
  int fails = 0;

  int cyc = 0, lowc = 0, last_low = 0, vcnt = 0;
  logic [23:0] last_data = '0;
  logic        last_ferr = 1'b0;
  int vt[$];
  int rises = 0, base = 0;

  int lowc1 = 0, last_low1 = 0, vcnt1 = 0;
  logic [23:0] last_data1 = '0;
  logic        last_ferr1 = 1'b0;
  int rises1 = 0, base1 = 0;

  always #5 clk = ~clk;

  adc_spi_multi_rx u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode_cont (mode_cont),
    .sdata     (sdata),
    .cs        (cs),
    .sclk      (sclk),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  adc_spi_multi_rx #(.CLK_DIV(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start1),
    .mode_cont (1'b0),
    .sdata     (sdata1),
    .cs        (cs1),
    .sclk      (sclk1),
    .data      (data1),
    .valid     (valid1),
    .frame_err (frame_err1),
    .busy      (busy1)
  );

  function automatic logic pick(input logic [15:0] w, input int idx);
    if (idx < 0 || idx > 15) return 1'b0;
    return w[15-idx];
  endfunction

  // ADC model: MSB presented at cs fall, next bit after every sclk rise.
  assign sdata  = {pick(w1, rises - base), pick(w0, rises - base)};
  assign sdata1 = {pick(w11, rises1 - base1), pick(w10, rises1 - base1)};

  always @(negedge cs)    base   = rises;
  always @(posedge sclk)  if (!cs) rises++;
  always @(negedge cs1)   base1  = rises1;
  always @(posedge sclk1) if (!cs1) rises1++;

  always @(negedge clk) begin
    cyc++;
    if (!cs) lowc++;
    else if (lowc != 0) begin last_low = lowc; lowc = 0; end
    if (valid) begin
      vcnt++;
      vt.push_back(cyc);
      last_data = data;
      last_ferr = frame_err;
    end
    if (!cs1) lowc1++;
    else if (lowc1 != 0) begin last_low1 = lowc1; lowc1 = 0; end
    if (valid1) begin
      vcnt1++;
      last_data1 = data1;
      last_ferr1 = frame_err1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_valid(input int target, input int budget, input string name);
    int n = 0;
    while (vcnt < target && n < budget) begin tick(1); n++; end
    if (vcnt < target) begin
      tests++; fails++;
      $display("FAIL %s timeout: valids %0d expected %0d", name, vcnt, target);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    tick(3);
    tests++; if (cs !== 1'b1) begin fails++; $display("FAIL rst_cs got %b exp 1", cs); end
    tests++; if (sclk !== 1'b1) begin fails++; $display("FAIL rst_sclk got %b exp 1", sclk); end
    tests++; if (data !== 24'h0) begin fails++; $display("FAIL rst_data got %h exp 0", data); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b exp 0", valid); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL rst_ferr got %b exp 0", frame_err); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b exp 0", busy); end
    rst = 1'b1;
    tick(3);
  endtask

  task automatic test_single();
    int v0 = vcnt;
    int r0;
    w0 = 16'h0ABC; w1 = 16'h0123;
    r0 = rises;
    pulse_start();
    wait_valid(v0 + 1, 300, "single");
    tick(10);
    tests++; if (last_data !== 24'h123ABC) begin fails++; $display("FAIL single_data got %h exp 123abc", last_data); end
    tests++; if (last_ferr !== 1'b0) begin fails++; $display("FAIL single_ferr got %b exp 0", last_ferr); end
    tests++; if (last_low !== 66) begin fails++; $display("FAIL single_cs_low got %0d exp 66", last_low); end
    tests++; if (rises - r0 !== 16) begin fails++; $display("FAIL single_rises got %0d exp 16", rises - r0); end
    tests++; if (vcnt - v0 !== 1) begin fails++; $display("FAIL single_valids got %0d exp 1", vcnt - v0); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy got %b exp 0", busy); end
  endtask

  task automatic test_frame_err();
    int v0 = vcnt;
    w0 = 16'h0ABC; w1 = 16'h8001;
    pulse_start();
    wait_valid(v0 + 1, 300, "ferr1");
    tick(10);
    tests++; if (last_data !== 24'h001ABC) begin fails++; $display("FAIL ferr_data got %h exp 001abc", last_data); end
    tests++; if (last_ferr !== 1'b1) begin fails++; $display("FAIL ferr_flag got %b exp 1", last_ferr); end
    tests++; if (frame_err !== 1'b1) begin fails++; $display("FAIL ferr_hold got %b exp 1", frame_err); end
    w1 = 16'h0123;
    pulse_start();
    wait_valid(v0 + 2, 300, "ferr2");
    tick(10);
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL ferr_clear got %b exp 0", frame_err); end
  endtask

  task automatic test_cont();
    int v0 = vcnt;
    int n0 = vt.size();
    int n = 0;
    w0 = 16'h0555; w1 = 16'h0AAA;
    @(negedge clk); mode_cont = 1'b1;
    wait_valid(v0 + 2, 400, "cont2");
    while (!(vcnt == v0 + 2 && !cs && (rises - base) >= 4) && n < 200) begin
      tick(1); n++;
    end
    mode_cont = 1'b0;
    wait_valid(v0 + 3, 200, "cont3");
    tick(150);
    tests++; if (vcnt - v0 !== 3) begin fails++; $display("FAIL cont_valids got %0d exp 3", vcnt - v0); end
    tests++; if (vt[n0+1] - vt[n0] !== 71) begin fails++; $display("FAIL cont_gap1 got %0d exp 71", vt[n0+1] - vt[n0]); end
    tests++; if (vt[n0+2] - vt[n0+1] !== 71) begin fails++; $display("FAIL cont_gap2 got %0d exp 71", vt[n0+2] - vt[n0+1]); end
    tests++; if (last_data !== 24'hAAA555) begin fails++; $display("FAIL cont_data got %h exp aaa555", last_data); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL cont_idle got %b exp 0", busy); end
  endtask

  task automatic test_reset_mid();
    int v0 = vcnt;
    int r0 = rises;
    int n = 0;
    w0 = 16'h0ABC; w1 = 16'h0123;
    pulse_start();
    while ((rises - r0) < 8 && n < 100) begin @(negedge clk); n++; end
    #1 rst = 1'b0;
    #1;
    tests++; if (cs !== 1'b1) begin fails++; $display("FAIL mid_cs got %b exp 1", cs); end
    tests++; if (sclk !== 1'b1) begin fails++; $display("FAIL mid_sclk got %b exp 1", sclk); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy got %b exp 0", busy); end
    tick(2);
    rst = 1'b1;
    tick(100);
    tests++; if (vcnt - v0 !== 0) begin fails++; $display("FAIL mid_novalid got %0d exp 0", vcnt - v0); end
    tests++; if (data !== 24'h0) begin fails++; $display("FAIL mid_data got %h exp 0", data); end
    w0 = 16'h0FFF; w1 = 16'h0555;
    pulse_start();
    wait_valid(v0 + 1, 300, "mid_fresh");
    tick(10);
    tests++; if (last_data !== 24'h555FFF) begin fails++; $display("FAIL mid_fresh got %h exp 555fff", last_data); end
    tests++; if (last_low !== 66) begin fails++; $display("FAIL mid_cs_low got %0d exp 66", last_low); end
  endtask

  task automatic test_start_busy();
    int v0 = vcnt;
    w0 = 16'h0321; w1 = 16'h0654;
    pulse_start();
    tick(30);
    pulse_start();
    tick(250);
    tests++; if (vcnt - v0 !== 1) begin fails++; $display("FAIL busy_start got %0d exp 1", vcnt - v0); end
    tests++; if (last_data !== 24'h654321) begin fails++; $display("FAIL busy_data got %h exp 654321", last_data); end
  endtask

  task automatic test_div1();
    int v0 = vcnt1;
    int n = 0;
    w10 = 16'h0FFF; w11 = 16'h0321;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    while (vcnt1 == v0 && n < 200) begin tick(1); n++; end
    tick(10);
    tests++; if (vcnt1 - v0 !== 1) begin fails++; $display("FAIL div1_valids got %0d exp 1", vcnt1 - v0); end
    tests++; if (last_data1 !== 24'h321FFF) begin fails++; $display("FAIL div1_data got %h exp 321fff", last_data1); end
    tests++; if (last_low1 !== 33) begin fails++; $display("FAIL div1_cs_low got %0d exp 33", last_low1); end
    tests++; if (last_ferr1 !== 1'b0) begin fails++; $display("FAIL div1_ferr got %b exp 0", last_ferr1); end
  endtask

  task automatic test_avg();
    int v0 = vcnt;
    logic [15:0] s0 [4];
    logic [15:0] s1 [4];
    s0[0] = 16'd100; s0[1] = 16'd101; s0[2] = 16'd102; s0[3] = 16'd104;
    s1[0] = 16'd8;   s1[1] = 16'd8;   s1[2] = 16'd8;   s1[3] = 16'd9;
    for (int f = 0; f < 3; f++) begin
      w0 = s0[f]; w1 = s1[f];
      pulse_start();
      tick(90);
    end
    tests++; if (vcnt - v0 !== 0) begin fails++; $display("FAIL avg_early got %0d exp 0", vcnt - v0); end
    w0 = s0[3]; w1 = s1[3];
    pulse_start();
    wait_valid(v0 + 1, 300, "avg");
    tick(10);
    tests++; if (vcnt - v0 !== 1) begin fails++; $display("FAIL avg_valids got %0d exp 1", vcnt - v0); end
    tests++; if (last_data[11:0] !== 12'd101) begin fails++; $display("FAIL avg_ch0 got %0d exp 101", last_data[11:0]); end
    tests++; if (last_data[23:12] !== 12'd8) begin fails++; $display("FAIL avg_ch1 got %0d exp 8", last_data[23:12]); end
    tests++; if (last_ferr !== 1'b0) begin fails++; $display("FAIL avg_ferr got %b exp 0", last_ferr); end
  endtask

  initial begin
    test_reset();
`ifdef ADC_RX_AVG_EN
    test_avg();
`else
    test_single();
    test_frame_err();
    test_cont();
    test_reset_mid();
    test_start_busy();
    test_div1();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
